// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, canonical NOP encoding, fetch-buffer entry.
// Latency: none (constants and types only).
// Backpressure: none.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries ahead of IF/ID.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the producer must never push when full without popping.
//
// Ports: clk/reset (sync, active-high); push/pushData write; pop advances the head;
// clear empties the FIFO in one cycle; headData/count/full/empty describe current state.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           pushData,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    used;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      used  <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({push, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: ;
      endcase
    end
  end

  assign headData = mem[rdPtr];
  assign count    = used;
  assign full     = (used == CW'(DEPTH));
  assign empty    = (used == '0);

  // The fetch credit scheme guarantees a free slot for every response.
  assert property (@(posedge clk) disable iff (reset) !(push && full && !pop && !clear));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues in-order imem requests, buffers responses.
// Latency: request accepted in N, response in N+L, instruction presented to IF/ID in N+L+1.
// Backpressure: StallF holds the head entry; issue stops once in-flight + buffered reaches FB_DEPTH.
//
// Ports: clk/reset (sync, active-high); StallF hold; PCSrcE/PCTargetE redirect;
// imem_req/imem_addr/imem_ready request side; imem_rvalid/imem_rdata in-order responses;
// InstrF/PCF/PCPlus4F/ValidF towards IF/ID.
// Optional macro FETCH_MISALIGN_TRAP_EN adds MisalignF: a misaligned redirect raises it and
// blocks issue until reset or the next aligned redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FB_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            ValidF
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            MisalignF
`endif
);

  localparam int CW = $clog2(FB_DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] reqPc;     // next address to request
  logic [XLEN-1:0] respPc;    // pc of the next response that will be kept
  logic [CW-1:0]   inflight;  // accepted, response not yet seen
  logic [CW-1:0]   discard;   // in-flight responses belonging to a squashed path
  logic [CW-1:0]   fifoCount;
  logic [CW:0]     committed;
  logic [XLEN-1:0] target;
  logic            fifoEmpty;
  logic            unusedFifoFull;
  logic            pop;
  logic            push;
  logic            accept;
  logic            issueBlock;
  logic [EW-1:0]   fifoHead;
  fetch_entry_t    head;
  fetch_entry_t    pushEntry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign <= 1'b0;
    end else if (PCSrcE) begin
      misalign <= (PCTargetE[1:0] != 2'b00);
    end
  end

  assign MisalignF  = misalign;
  assign issueBlock = misalign;
`else
  logic unusedTargetLsbs;
  assign unusedTargetLsbs = ^PCTargetE[1:0];
  assign issueBlock       = 1'b0;
`endif

  assign target = {PCTargetE[XLEN-1:2], 2'b00};

  assign pop = ValidF && !StallF && !PCSrcE;

  // Slots already spoken for: responses still owed plus entries buffered, less the one leaving now.
  assign committed = {1'b0, inflight} + {1'b0, fifoCount} - {{CW{1'b0}}, pop};
  assign imem_req  = !reset && !PCSrcE && !issueBlock && (committed < (CW+1)'(FB_DEPTH));
  assign imem_addr = reqPc;
  assign accept    = imem_req && imem_ready;

  // A response landing in the redirect cycle belongs to the old path and is dropped.
  assign push = imem_rvalid && !PCSrcE && (discard == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      reqPc    <= RESET_PC;
      respPc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      case ({accept, imem_rvalid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
      if (PCSrcE) begin
        reqPc   <= target;
        respPc  <= target;
        discard <= inflight - CW'(imem_rvalid);
      end else begin
        if (accept) begin
          reqPc <= reqPc + 32'd4;
        end
        if (imem_rvalid) begin
          if (discard != '0) begin
            discard <= discard - CW'(1);
          end else begin
            respPc <= respPc + 32'd4;
          end
        end
      end
    end
  end

  assign pushEntry.pc    = respPc;
  assign pushEntry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (FB_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (PCSrcE),
    .pushData (pushEntry),
    .headData (fifoHead),
    .count    (fifoCount),
    .full     (unusedFifoFull),
    .empty    (fifoEmpty)
  );

  assign head     = fifoHead;
  assign ValidF   = !fifoEmpty;
  assign InstrF   = fifoEmpty ? NOP_INSTR : head.instr;
  assign PCF      = fifoEmpty ? respPc : head.pc;
  assign PCPlus4F = PCF + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for reset/stream/stall/redirect/ready-low/wrap/reset,
// then randomized stalls, redirects and memory timing against an in-order fetch-stream model.
// Prints one summary line.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        MisalignF;
`endif

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FB_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .ValidF      (ValidF)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .MisalignF   (MisalignF)
`endif
  );

  int passCnt  = 0;
  int totalCnt = 0;

  // Memory contents: each word's instruction is a fixed function of its address.
  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) | 32'h0000_0003;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] target;
    logic        ready, rv;
    logic [31:0] raddr;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  function automatic vec_t mk(input int unsigned rst, stall, redir, target, ready, rv, raddr,
                              input int unsigned eReq, eAddr, eValid, ePc);
    vec_t v;
    v.rst = (rst != 0); v.stall = (stall != 0); v.redir = (redir != 0); v.target = target;
    v.ready = (ready != 0); v.rv = (rv != 0); v.raddr = raddr;
    v.eReq = (eReq != 0); v.eAddr = eAddr; v.eValid = (eValid != 0); v.ePc = ePc;
    return v;
  endfunction

  // ---------------- random-phase memory and model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq [$];
  int          cyc = 0;
  int          lastDue = 0;
  logic [31:0] expPc;        // next pc IF/ID should receive
  logic [31:0] expReqAddr;   // next address the fetcher should request
  logic        prevRedir;
  logic        prevHold;
  logic [31:0] prevPc;
  int          idle = 0;
  int          consumed = 0;

  task automatic applyReset();
    @(posedge clk); #1;
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    lastDue = cyc;
    expPc = 32'h0; expReqAddr = 32'h0;
    prevRedir = 1'b0; prevHold = 1'b0; prevPc = 32'h0; idle = 0;
  endtask

  task automatic randCycle(input logic stall, input logic redir, input logic [31:0] tgt, input logic rdy);
    int due;
    @(posedge clk); cyc++;
    #1;
    StallF = stall; PCSrcE = redir; PCTargetE = tgt; imem_ready = rdy;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = instrOf(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    end
    #3;
    if (prevRedir) check("bubble after redirect", ValidF, 0);
    else if (prevHold) begin
      check("stall holds valid", ValidF, 1);
      check("stall holds pc", PCF, prevPc);
    end
    if (ValidF) begin
      check("in-order pc", PCF, expPc);
      check("instr matches pc", InstrF, instrOf(PCF));
    end else begin
      check("bubble is nop", InstrF, NOP_INSTR);
    end
    check("pcplus4", PCPlus4F, PCF + 32'd4);
    if (redir) check("no request on redirect", imem_req, 0);
    if (imem_rvalid) void'(mq.pop_front());
    if (imem_req && imem_ready) begin
      check("sequential request addr", imem_addr, expReqAddr);
      expReqAddr = expReqAddr + 32'd4;
      due = cyc + int'($urandom_range(1, 3));
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      mq.push_back('{addr: imem_addr, due: due});
    end
    check("outstanding within depth", (mq.size() <= 2), 1);
    prevRedir = redir;
    prevHold  = ValidF && stall && !redir;
    prevPc    = PCF;
    if (redir) begin
      expPc      = {tgt[31:2], 2'b00};
      expReqAddr = {tgt[31:2], 2'b00};
    end else if (ValidF && !stall) begin
      expPc = expPc + 32'd4;
      consumed++;
      idle = 0;
    end
    idle++;
    if (idle > 60) begin
      check("fetch progress idle cycles", idle, 60);
      idle = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    //               rst st rd target        rdy rv raddr          eReq eAddr         eV ePc
    vecs[0]  = mk(1, 0, 0, 0,            1, 0, 0,            0, 0,            0, 0);
    vecs[1]  = mk(0, 0, 0, 0,            1, 0, 0,            1, 0,            0, 0);
    vecs[2]  = mk(0, 0, 0, 0,            1, 1, 0,            1, 4,            0, 0);
    vecs[3]  = mk(0, 0, 0, 0,            1, 1, 4,            1, 8,            1, 0);
    vecs[4]  = mk(0, 0, 0, 0,            1, 1, 8,            1, 12,           1, 4);
    vecs[5]  = mk(0, 1, 0, 0,            1, 1, 12,           0, 16,           1, 8);
    vecs[6]  = mk(0, 1, 0, 0,            1, 0, 0,            0, 16,           1, 8);
    vecs[7]  = mk(0, 1, 0, 0,            1, 0, 0,            0, 16,           1, 8);
    vecs[8]  = mk(0, 0, 0, 0,            1, 0, 0,            1, 16,           1, 8);
    vecs[9]  = mk(0, 0, 0, 0,            1, 1, 16,           1, 20,           1, 12);
    vecs[10] = mk(0, 0, 0, 0,            1, 0, 0,            1, 24,           1, 16);
    vecs[11] = mk(0, 0, 1, 32'h100,      1, 0, 0,            0, 28,           0, 20);
    vecs[12] = mk(0, 0, 0, 0,            1, 1, 20,           0, 32'h100,      0, 32'h100);
    vecs[13] = mk(0, 0, 0, 0,            1, 1, 24,           1, 32'h100,      0, 32'h100);
    vecs[14] = mk(0, 0, 0, 0,            1, 1, 32'h100,      1, 32'h104,      0, 32'h100);
    vecs[15] = mk(0, 0, 0, 0,            1, 1, 32'h104,      1, 32'h108,      1, 32'h100);
    vecs[16] = mk(0, 1, 1, 32'h200,      1, 1, 32'h108,      0, 32'h10C,      1, 32'h104);
    vecs[17] = mk(0, 0, 0, 0,            1, 0, 0,            1, 32'h200,      0, 32'h200);
    vecs[18] = mk(0, 0, 0, 0,            0, 1, 32'h200,      1, 32'h204,      0, 32'h200);
    vecs[19] = mk(0, 0, 0, 0,            0, 0, 0,            1, 32'h204,      1, 32'h200);
    vecs[20] = mk(0, 0, 0, 0,            0, 0, 0,            1, 32'h204,      0, 32'h204);
    vecs[21] = mk(0, 0, 0, 0,            0, 0, 0,            1, 32'h204,      0, 32'h204);
    vecs[22] = mk(0, 0, 0, 0,            1, 0, 0,            1, 32'h204,      0, 32'h204);
    vecs[23] = mk(0, 0, 0, 0,            1, 1, 32'h204,      1, 32'h208,      0, 32'h204);
    vecs[24] = mk(0, 0, 0, 0,            1, 1, 32'h208,      1, 32'h20C,      1, 32'h204);
    vecs[25] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h20C,     0, 32'h210,      1, 32'h208);
    vecs[26] = mk(0, 0, 0, 0,            1, 0, 0,            1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    vecs[27] = mk(0, 0, 0, 0,            1, 1, 32'hFFFF_FFFC, 1, 0,           0, 32'hFFFF_FFFC);
    vecs[28] = mk(0, 0, 0, 0,            1, 1, 0,            1, 4,            1, 32'hFFFF_FFFC);
    vecs[29] = mk(0, 0, 0, 0,            0, 0, 0,            1, 8,            1, 0);
    vecs[30] = mk(1, 0, 0, 0,            1, 0, 0,            0, 8,            0, 4);
    vecs[31] = mk(1, 0, 0, 0,            1, 0, 0,            0, 0,            0, 0);
    vecs[32] = mk(0, 0, 0, 0,            1, 0, 0,            1, 0,            0, 0);

    @(posedge clk); @(posedge clk);
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      reset       = vecs[i].rst;
      StallF      = vecs[i].stall;
      PCSrcE      = vecs[i].redir;
      PCTargetE   = vecs[i].target;
      imem_ready  = vecs[i].ready;
      imem_rvalid = vecs[i].rv;
      imem_rdata  = vecs[i].rv ? instrOf(vecs[i].raddr) : 32'h0;
      #3;
      check($sformatf("vec%0d imem_req", i),  imem_req,  vecs[i].eReq);
      check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].eAddr);
      check($sformatf("vec%0d ValidF", i),    ValidF,    vecs[i].eValid);
      check($sformatf("vec%0d PCF", i),       PCF,       vecs[i].ePc);
      check($sformatf("vec%0d PCPlus4F", i),  PCPlus4F,  vecs[i].ePc + 32'd4);
      check($sformatf("vec%0d InstrF", i),    InstrF,
            vecs[i].eValid ? instrOf(vecs[i].ePc) : NOP_INSTR);
    end

    // Randomized stalls, redirects, ready gaps and response latencies.
    applyReset();
    for (int n = 0; n < 3000; n++) begin
      logic        st, rd, rdy;
      logic [31:0] tg;
      st  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else                           tg = 32'($urandom_range(0, 1023)) << 2;
      randCycle(st, rd, tg, rdy);
    end
    check("instructions consumed above floor", (consumed > 500), 1);

`ifdef FETCH_MISALIGN_TRAP_EN
    applyReset();
    for (int n = 0; n < 5; n++) randCycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("misalign clear after reset", MisalignF, 0);
    randCycle(1'b0, 1'b1, 32'h102, 1'b1);
    for (int n = 0; n < 6; n++) begin
      randCycle(1'b0, 1'b0, 32'h0, 1'b1);
      check("misalign flag set", MisalignF, 1);
      check("misalign blocks issue", imem_req, 0);
    end
    randCycle(1'b0, 1'b1, 32'h200, 1'b1);
    randCycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("misalign cleared by aligned redirect", MisalignF, 0);
    check("fetch resumes req", imem_req, 1);
    check("fetch resumes addr", imem_addr, 32'h200);
    idle = 0;
    for (int n = 0; n < 10; n++) randCycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("fetch reached past target", expPc > 32'h200, 1);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
